// File: rtl/crc_serial_codec.sv
// crc_serial_codec: MSB-first serial CRC framer emitting {msg, crc} per frame.
// Define CRC_CHECK_EN to add a check mode that validates received codewords.
module crc_serial_codec #(
   parameter int MSG_W = 5,
   parameter int CRC_W = 3,
   parameter logic [CRC_W-1:0] POLY = 3'b011
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   ena,
   input  logic                   bit_en,
   input  logic                   din,
   input  logic                   clear,
`ifdef CRC_CHECK_EN
   input  logic                   mode,
   output logic                   crc_ok,
`endif
   output logic [MSG_W+CRC_W-1:0] frame_out,
   output logic                   frame_valid,
   output logic                   busy
);
   localparam int FW = MSG_W + CRC_W;
   localparam int CW = $clog2(FW + 1);
`ifdef CRC_CHECK_EN
   localparam int MW = FW;
`else
   localparam int MW = MSG_W;
`endif
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t state, state_next;
   logic [MW-1:0] msg, msg_next;
   logic [CRC_W-1:0] crc, crc_next;
   logic [CW-1:0] cnt, cnt_next, len;
   logic take, fb, last;
   // DONE is a one-cycle flush slot, so bits arriving there are ignored
   assign take = ena & bit_en & ~clear & (state != DONE);
   assign busy = state == SHIFT;
`ifdef CRC_CHECK_EN
   logic mode_r, chk;
   // mode is only honoured while idle; a running frame keeps its latched mode
   assign chk = (state == IDLE) ? mode : mode_r;
   assign len = chk ? CW'(FW) : CW'(MSG_W);
`else
   assign len = CW'(MSG_W);
`endif
   always_comb begin
      fb = din ^ crc[CRC_W-1];
      crc_next = CRC_W'({crc, 1'b0}) ^ (fb ? POLY : '0);
      msg_next = MW'({msg, din});
      cnt_next = cnt + 1'b1;
      last = cnt_next == len;
      state_next = state;
      if (ena) state_next = clear ? IDLE : take ? (last ? DONE : SHIFT) : (state == DONE) ? IDLE : state;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         msg <= '0;
         crc <= '0;
         cnt <= '0;
         frame_out <= '0;
         frame_valid <= 1'b0;
`ifdef CRC_CHECK_EN
         mode_r <= 1'b0;
         crc_ok <= 1'b0;
`endif
      end else if (ena) begin
         state <= state_next;
         frame_valid <= take & last;
         if (clear || state == DONE) begin
            msg <= '0;
            crc <= '0;
            cnt <= '0;
         end else if (take) begin
            msg <= msg_next;
            crc <= crc_next;
            cnt <= cnt_next;
         end
`ifdef CRC_CHECK_EN
         if (state == IDLE) mode_r <= mode;
         if (take && last) begin
            frame_out <= chk ? msg_next : {msg_next[MSG_W-1:0], crc_next};
            if (chk) crc_ok <= crc_next == '0;
         end
`else
         if (take && last) frame_out <= {msg_next, crc_next};
`endif
      end
   end
endmodule

// File: tb/tb_crc_serial_codec.sv
// tb_crc_serial_codec: directed checks of crc_serial_codec with default parameters.
// Check-mode vectors run only when CRC_CHECK_EN is defined.
module tb_crc_serial_codec;
   logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1, bit_en = 1'b0, din = 1'b0, clear = 1'b0;
   logic [7:0] frame_out;
   logic frame_valid, busy;
   int passed = 0, total = 0;
`ifdef CRC_CHECK_EN
   logic mode = 1'b0, crc_ok;
`endif
   crc_serial_codec dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .bit_en(bit_en), .din(din), .clear(clear),
`ifdef CRC_CHECK_EN
      .mode(mode), .crc_ok(crc_ok),
`endif
      .frame_out(frame_out), .frame_valid(frame_valid), .busy(busy)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
   endtask
   task automatic step(input logic e, input logic b, input logic c);
      @(negedge clk);
      bit_en = e;
      din = b;
      clear = c;
   endtask
   task automatic send(input logic [7:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) step(1'b1, v[i], 1'b0);
   endtask
   initial begin
      @(negedge clk);
      @(negedge clk);
      check("rst_frame", frame_out, 0);
      check("rst_valid", frame_valid, 0);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;
      // basic frame 11010 -> D2
      step(1, 1, 0);
      step(1, 1, 0);
      check("t1_busy", busy, 1);
      send(8'b010, 3);
      step(0, 0, 0);
      check("t1_valid", frame_valid, 1);
      check("t1_frame", frame_out, 8'hD2);
      check("t1_busy_done", busy, 0);
      step(0, 0, 0);
      check("t1_pulse_end", frame_valid, 0);
      check("t1_hold", frame_out, 8'hD2);
      // bit_en gap between bits 2 and 3
      send(8'b11, 2);
      step(0, 0, 0);
      check("t2_gap_busy0", busy, 1);
      step(0, 0, 0);
      step(0, 0, 0);
      check("t2_gap_busy2", busy, 1);
      check("t2_gap_valid", frame_valid, 0);
      send(8'b010, 3);
      step(0, 0, 0);
      check("t2_valid", frame_valid, 1);
      check("t2_frame", frame_out, 8'hD2);
      step(0, 0, 0);
      // frame 10110 -> B0, then clear aborts the next frame
      send(8'b10110, 5);
      step(0, 0, 0);
      check("t3_pre_frame", frame_out, 8'hB0);
      step(0, 0, 0);
      send(8'b11, 2);
      step(1, 0, 1);
      step(0, 0, 0);
      check("t3_clr_busy", busy, 0);
      check("t3_clr_hold", frame_out, 8'hB0);
      check("t3_clr_valid", frame_valid, 0);
      send(8'b11010, 5);
      step(0, 0, 0);
      check("t3_valid", frame_valid, 1);
      check("t3_frame", frame_out, 8'hD2);
      step(0, 0, 0);
      // asynchronous reset mid-frame
      send(8'b11, 2);
      step(0, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      check("t4_rst_frame", frame_out, 0);
      check("t4_rst_valid", frame_valid, 0);
      check("t4_rst_busy", busy, 0);
      #1 rst_n = 1'b1;
      send(8'b10110, 5);
      step(0, 0, 0);
      check("t4_valid", frame_valid, 1);
      check("t4_frame", frame_out, 8'hB0);
      step(0, 0, 0);
      // ena low freezes a partial frame and a pending pulse
      send(8'b11, 2);
      step(0, 0, 0);
      ena = 1'b0;
      repeat (4) step(1, 1, 0);
      check("t5_frz_busy", busy, 1);
      check("t5_frz_frame", frame_out, 8'hB0);
      step(0, 0, 0);
      ena = 1'b1;
      send(8'b010, 3);
      step(0, 0, 0);
      check("t5_valid", frame_valid, 1);
      check("t5_frame", frame_out, 8'hD2);
      ena = 1'b0;
      step(0, 0, 0);
      step(0, 0, 0);
      check("t5_frz_pulse", frame_valid, 1);
      ena = 1'b1;
      step(0, 0, 0);
      check("t5_pulse_end", frame_valid, 0);
`ifdef CRC_CHECK_EN
      step(0, 0, 0);
      mode = 1'b1;
      send(8'b11010010, 8);
      step(0, 0, 0);
      check("t6_ok_valid", frame_valid, 1);
      check("t6_ok", crc_ok, 1);
      check("t6_ok_frame", frame_out, 8'hD2);
      step(0, 0, 0);
      send(8'b11000010, 8);
      step(0, 0, 0);
      check("t6_bad_valid", frame_valid, 1);
      check("t6_bad", crc_ok, 0);
      check("t6_bad_frame", frame_out, 8'hC2);
      mode = 1'b0;
      step(0, 0, 0);
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/crc_serial_codec.md
CRC_SERIAL_CODEC -- requirements
Module: crc_serial_codec

Interface
- REQ-001 SHALL have parameter MSG_W, default 5: message bits per frame; legal range 1..32.
- REQ-002 SHALL have parameter CRC_W, default 3: CRC width; legal range 2..16.
- REQ-003 SHALL have parameter POLY, default 3'b011 (x^3+x+1): generator polynomial without the implicit x^CRC_W term; POLY[0] SHALL be 1.
- REQ-004 SHALL have port clk, input, 1: single clock; never gated.
- REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
- REQ-006 SHALL have port ena, input, 1: global enable; when 0 all state holds.
- REQ-007 SHALL have port bit_en, input, 1: din is valid this cycle.
- REQ-008 SHALL have port din, input, 1: serial data, MSB first.
- REQ-009 SHALL have port clear, input, 1: synchronous frame abort.
- REQ-010 SHALL have port frame_out, output, MSG_W+CRC_W: registered {msg, crc}.
- REQ-011 SHALL have port frame_valid, output, 1: one-cycle completion pulse.
- REQ-012 SHALL have port busy, output, 1: high while a frame is partially received.

Function
- REQ-013 SHALL implement FSM states IDLE, SHIFT and DONE.
- REQ-014 IDLE -> SHIFT SHALL occur on the first accepted bit; a bit is accepted when ena=1, bit_en=1 and clear=0.
- REQ-015 Per accepted bit, fb = din ^ crc[CRC_W-1]; crc <= (crc << 1) ^ (fb ? POLY : 0), truncated to CRC_W bits.
- REQ-016 Generate mode: SHALL shift din into msg (left shift, LSB in) for MSG_W accepted bits; a bit counter of width $clog2(MSG_W+CRC_W+1) SHALL count accepted bits.
- REQ-017 On the cycle the last bit is accepted: frame_out <= {msg_next, crc_next}; frame_valid <= 1 for exactly one cycle (latency 1 clk after last bit); FSM -> DONE.
- REQ-018 DONE SHALL clear msg, crc and counter, then -> IDLE the next cycle; frame_out SHALL hold until the next frame completes.
- REQ-019 bit_en=0 mid-frame SHALL hold all state (no timeout).
- REQ-020 clear=1 (with ena=1) SHALL reset FSM, msg, crc and counter to zero and drop any simultaneous bit; frame_out SHALL be unaffected.
- REQ-021 busy SHALL be 1 in SHIFT and 0 in IDLE and DONE.
- REQ-022 ena=0 SHALL freeze everything, including a pending frame_valid pulse.

Reset
- REQ-023 rst_n=0 SHALL asynchronously force IDLE, with msg, crc, counter, frame_out, frame_valid and busy all set to 0.
- REQ-024 Reset mid-frame SHALL discard the partial frame; the next accepted bit SHALL start a new frame.

Configuration
- REQ-025 Macro CRC_CHECK_EN, when defined, SHALL add input mode (0=generate, 1=check) and output crc_ok (registered, reset 0).
- REQ-026 With the macro, check mode SHALL accept MSG_W+CRC_W bits through the same LFSR; at completion crc_ok <= (crc_next == 0), frame_out <= received codeword, and frame_valid SHALL pulse; mode SHALL be sampled only in IDLE.
- REQ-027 Without the macro, mode and crc_ok SHALL be absent and behaviour SHALL be generate-only.

Verification (defaults MSG_W=5, CRC_W=3, POLY=3'b011)
- REQ-028 Bits 1,1,0,1,0 on consecutive cycles -> frame_out=8'hD2 and frame_valid high for one cycle after the fifth bit.
- REQ-029 Same bits with bit_en low for 3 cycles between bits 2 and 3 -> same 8'hD2; busy held high throughout the gap.
- REQ-030 clear asserted together with bit 3, then 1,1,0,1,0 sent -> 8'hD2; the previous frame_out holds until then.
- REQ-031 rst_n pulsed low after 2 bits -> all outputs 0 at once; a new 5-bit frame 1,0,1,1,0 -> 8'hB0.
- REQ-032 CRC_CHECK_EN, mode=1, bits 1,1,0,1,0,0,1,0 -> crc_ok=1; same with bit 4 flipped -> crc_ok=0.
- REQ-033 ena=0 for 4 cycles mid-frame -> state frozen; resuming gives the correct 8'hD2.
